// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, GF(2^8) arithmetic, S-box functions and rcon table
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DEC    = 2'd2,
        ST_DONE   = 2'd3
    } aes_fsm_t;

    // Index 0 is unused so that RCON[i] is the constant of round i
    localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                                           8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] rcon_at(input logic [3:0] i);
        logic [7:0] v;
        v = 8'h00;
        if (i <= 4'd10) v = RCON[i];
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
        return gf_mul(r, r);
    endfunction

    // S-box evaluated from its algebraic definition: inverse, then affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
                 ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t i_state,
    input  aes_state_t i_rk,
    input  logic       i_last,
    output aes_state_t o_state
);

    aes_state_t w_sub;
    aes_state_t w_ark;
    aes_state_t w_mix;
    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    // InvShiftRows folded into the InvSubBytes byte selection; byte n = 4*col + row
    always_comb begin
        w_sub = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sub[127 - 8*(4*c + r) -: 8] =
                    inv_sbox(i_state[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
    end

    assign w_ark = w_sub ^ i_rk;

    // InvMixColumns on each column of the key-added state
    always_comb begin
        w_mix = '0;
        w_a0  = '0;
        w_a1  = '0;
        w_a2  = '0;
        w_a3  = '0;
        for (int c = 0; c < 4; c++) begin
            w_a0 = w_ark[127 - 32*c -: 8];
            w_a1 = w_ark[119 - 32*c -: 8];
            w_a2 = w_ark[111 - 32*c -: 8];
            w_a3 = w_ark[103 - 32*c -: 8];
            w_mix[127 - 32*c -: 8] = gf_mul14(w_a0) ^ gf_mul11(w_a1) ^ gf_mul13(w_a2) ^ gf_mul9(w_a3);
            w_mix[119 - 32*c -: 8] = gf_mul9(w_a0)  ^ gf_mul14(w_a1) ^ gf_mul11(w_a2) ^ gf_mul13(w_a3);
            w_mix[111 - 32*c -: 8] = gf_mul13(w_a0) ^ gf_mul9(w_a1)  ^ gf_mul14(w_a2) ^ gf_mul11(w_a3);
            w_mix[103 - 32*c -: 8] = gf_mul11(w_a0) ^ gf_mul13(w_a1) ^ gf_mul9(w_a2)  ^ gf_mul14(w_a3);
        end
    end

    assign o_state = i_last ? w_ark : w_mix;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// rtl/aes128_decrypt_iter.sv - iterative AES-128 decryptor, one round per clock; optional AES_DEC_KEYCACHE_EN round-10 key cache
module aes128_decrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    input  logic         key_reuse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);

    aes_fsm_t   r_fsm;
    aes_fsm_t   w_fsm_next;
    aes_state_t r_state;
    aes_state_t r_rk;
    aes_state_t r_pt;
    logic [7:0] r_rcon;
    logic [3:0] r_cnt;

    logic       w_reuse;
    aes_state_t w_cache;
    logic       w_last_expand;
    logic       w_last_round;
    logic [7:0] w_rcon_inv;
    logic [31:0] w_k0, w_k1, w_k2, w_k3;
    logic [31:0] w_f0, w_f1, w_f2, w_f3;
    logic [31:0] w_p0, w_p1, w_p2, w_p3;
    aes_state_t w_rk_fwd;
    aes_state_t w_rk_inv;
    aes_state_t w_round_out;

    assign {w_k0, w_k1, w_k2, w_k3} = r_rk;
    assign w_last_expand = (r_cnt == 4'd10);
    assign w_last_round  = (r_cnt == 4'd0);

    // Forward schedule: rk_{i} -> rk_{i+1}
    assign w_f0     = w_k0 ^ sub_word(rot_word(w_k3)) ^ {r_rcon, 24'h0};
    assign w_f1     = w_k1 ^ w_f0;
    assign w_f2     = w_k2 ^ w_f1;
    assign w_f3     = w_k3 ^ w_f2;
    assign w_rk_fwd = {w_f0, w_f1, w_f2, w_f3};

    // Inverse schedule: rk_{r+1} -> rk_{r}, rcon taken from the counter
    assign w_rcon_inv = rcon_at(r_cnt + 4'd1);
    assign w_p3       = w_k3 ^ w_k2;
    assign w_p2       = w_k2 ^ w_k1;
    assign w_p1       = w_k1 ^ w_k0;
    assign w_p0       = w_k0 ^ sub_word(rot_word(w_p3)) ^ {w_rcon_inv, 24'h0};
    assign w_rk_inv   = {w_p0, w_p1, w_p2, w_p3};

    aes_inv_round u_round (
        .i_state (r_state),
        .i_rk    (w_rk_inv),
        .i_last  (w_last_round),
        .o_state (w_round_out)
    );

`ifdef AES_DEC_KEYCACHE_EN
    aes_state_t r_cache;

    // Remember the last expanded round-10 key for key_reuse requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache <= '0;
        end else if (r_fsm == ST_EXPAND && w_last_expand) begin
            r_cache <= w_rk_fwd;
        end
    end

    assign w_reuse = key_reuse;
    assign w_cache = r_cache;
`else
    logic w_unused_key_reuse;
    assign w_unused_key_reuse = key_reuse;
    assign w_reuse            = 1'b0;
    assign w_cache            = '0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= ST_IDLE;
        else        r_fsm <= w_fsm_next;
    end

    // Next-state and status outputs; outputs decode only the registered state
    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (r_fsm)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_fsm_next = w_reuse ? ST_DEC : ST_EXPAND;
            end
            ST_EXPAND: begin
                busy = 1'b1;
                if (w_last_expand) w_fsm_next = ST_DEC;
            end
            ST_DEC: begin
                busy = 1'b1;
                if (w_last_round) w_fsm_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_next = ST_IDLE;
            end
            default: w_fsm_next = ST_IDLE;
        endcase
    end

    // Datapath: capture, key expansion, inverse rounds, plaintext hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_rk    <= '0;
            r_pt    <= '0;
            r_rcon  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_reuse) begin
                            r_state <= ct ^ w_cache;
                            r_rk    <= w_cache;
                            r_cnt   <= 4'd9;
                        end else begin
                            r_state <= ct;
                            r_rk    <= key;
                            r_rcon  <= 8'h01;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                ST_EXPAND: begin
                    r_rk   <= w_rk_fwd;
                    r_rcon <= xtime(r_rcon);
                    if (w_last_expand) begin
                        r_state <= r_state ^ w_rk_fwd;
                        r_cnt   <= 4'd9;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DEC: begin
                    r_state <= w_round_out;
                    r_rk    <= w_rk_inv;
                    if (w_last_round) r_pt  <= w_round_out;
                    else              r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign pt = r_pt;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb/tb_aes128_decrypt_iter.sv - self-checking bench for aes128_decrypt_iter
module tb_aes128_decrypt_iter;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [4];

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         key_reuse = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] ct        = '0;
    logic [127:0] key       = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] pt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_acc    = 0;
    int t_first  = 0;
    logic [127:0] sb_q [$];

    aes128_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .key_reuse (key_reuse),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_v(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] c, input logic [127:0] k, input logic r,
                        input logic [127:0] exp, input string tag);
        int guard;
        guard     = 0;
        ct        = c;
        key       = k;
        key_reuse = r;
        in_valid  = 1'b1;
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        check_b({tag, "_accept_ready"}, in_ready, 1'b1);
        step();
        t_acc = cyc;
        sb_q.push_back(exp);
        in_valid  = 1'b0;
        ct        = '0;
        key       = '0;
        key_reuse = 1'b0;
    endtask

    task automatic wait_out(input int exp_lat, input logic [127:0] exp_pt, input string tag);
        int guard;
        int busy_cnt;
        guard    = 0;
        busy_cnt = 0;
        while (!out_valid && guard < 100) begin
            if (busy) busy_cnt++;
            step();
            guard++;
        end
        check_b({tag, "_out_valid"}, out_valid, 1'b1);
        check_i({tag, "_latency"}, cyc - t_acc, exp_lat);
        check_i({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        check_b({tag, "_in_ready_in_done"}, in_ready, 1'b0);
        check_v({tag, "_pt"}, pt, exp_pt);
    endtask

    // Scoreboard: pop one expected plaintext per output handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_pt: unexpected output %h, want none", pt);
                end else begin
                    check_v("sb_pt", pt, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        vecs[0] = '{ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{ct:  128'h3925841d02dc09fbdc118597196a0b32,
                    key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    key: 128'h00000000000000000000000000000000,
                    pt:  128'h00000000000000000000000000000000};
        vecs[3] = '{ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h6bc1bee22e409f96e93d7e117393172a};

        #1 rst_n = 1'b0;
        #2;
        check_b("rst_in_ready", in_ready, 1'b1);
        check_b("rst_out_valid", out_valid, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_v("rst_pt", pt, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].ct, vecs[i].key, 1'b0, vecs[i].pt, "vec");
            wait_out(20, vecs[i].pt, "vec");
            step();
            check_b("vec_handshake_in_ready", in_ready, 1'b1);
            check_b("vec_handshake_out_valid", out_valid, 1'b0);
            check_v("vec_pt_hold", pt, vecs[i].pt);
        end

        out_ready = 1'b0;
        send(vecs[0].ct, vecs[0].key, 1'b0, vecs[0].pt, "bp");
        wait_out(20, vecs[0].pt, "bp");
        for (int i = 0; i < 15; i++) begin
            in_valid = i[0];
            ct       = vecs[1].ct;
            key      = vecs[1].key;
            step();
            check_b("bp_out_valid", out_valid, 1'b1);
            check_v("bp_pt", pt, vecs[0].pt);
            check_b("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_b("bp_release_in_ready", in_ready, 1'b1);
        check_b("bp_release_out_valid", out_valid, 1'b0);

        send(vecs[1].ct, vecs[1].key, 1'b0, vecs[1].pt, "rst_mid");
        repeat (6) step();
        check_b("rst_mid_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_b("rst_mid_in_ready", in_ready, 1'b1);
        check_b("rst_mid_out_valid", out_valid, 1'b0);
        check_b("rst_mid_busy", busy, 1'b0);
        check_v("rst_mid_pt", pt, '0);
        sb_q.delete();
        step();
        rst_n = 1'b1;
        step();
        send(vecs[0].ct, vecs[0].key, 1'b0, vecs[0].pt, "after_rst");
        wait_out(20, vecs[0].pt, "after_rst");
        step();

`ifdef AES_DEC_KEYCACHE_EN
        send(vecs[0].ct, vecs[0].key, 1'b0, vecs[0].pt, "cache_fill");
        wait_out(20, vecs[0].pt, "cache_fill");
        step();
        send(vecs[0].ct, '0, 1'b1, vecs[0].pt, "reuse");
        wait_out(10, vecs[0].pt, "reuse");
        step();
`else
        send(vecs[0].ct, vecs[0].key, 1'b1, vecs[0].pt, "reuse_ignored");
        wait_out(20, vecs[0].pt, "reuse_ignored");
        step();
`endif

        send(vecs[1].ct, vecs[1].key, 1'b0, vecs[1].pt, "b2b_a");
        t_first = t_acc;
        wait_out(20, vecs[1].pt, "b2b_a");
        send(vecs[3].ct, vecs[3].key, 1'b0, vecs[3].pt, "b2b_b");
        check_b("b2b_gap_after_handshake", (t_acc - t_first) >= 22, 1'b1);
        wait_out(20, vecs[3].pt, "b2b_b");
        step();

        check_i("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
